// File: rtl/mem_stream_pkg.sv
// Shared types for the memory stream source: FSM states, read-tag layout and
// the output-buffer sizing rule.
package mem_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  // Room for every read in flight plus one word held and one being popped.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small circular FIFO with synchronous flush; head is visible whenever non-empty.
module stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/mem_stream_src.sv
// Streams a run-time window of a synchronous-read memory to a valid/ready
// consumer, with loop, abort and arbitrary read latency.
module mem_stream_src
  import mem_stream_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              loop_en,
  input  logic              abort,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int FIFO_DEPTH = fifo_depth(RD_LAT);
  localparam int CNT_W      = $clog2(FIFO_DEPTH+1);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [ADDR_W:0]         len_q, len_d, idx_q, idx_d;
  logic                    done_q, done_d;
  tag_t [RD_LAT-1:0]       vld_pipe_q, vld_pipe_d;
  tag_t                    tag_out;

  logic                    issue, flush, pop, push, pass_end;
  logic [CNT_W:0]          inflight, outstanding;
  logic [CNT_W-1:0]        fifo_cnt;
  logic                    fifo_empty, fifo_full;
  logic [DATA_W:0]         fifo_head;

  assign tag_out     = vld_pipe_q[RD_LAT-1];
  assign pass_end    = (idx_q == len_q - 1'b1);
  assign pop         = !fifo_empty && out_ready;
  assign push        = tag_out.vld && !flush;
  assign outstanding = inflight + (CNT_W+1)'(fifo_cnt);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + (CNT_W+1)'(vld_pipe_q[i].vld);
  end

  // Credit counts reads in flight plus buffered words; a same-cycle pop is
  // deliberately not credited so the buffer can never overflow.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (length != '0) begin
            base_d  = base_addr;
            len_d   = length;
            idx_d   = '0;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else if (outstanding < (CNT_W+1)'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (pass_end) begin
            idx_d = '0;
            if (!loop_en) state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else if (pop && fifo_head[DATA_W] && outstanding == (CNT_W+1)'(1)) begin
          // Only the final word remains, so an earlier pass's last can't end us.
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d         = vld_pipe_q;
    vld_pipe_d[0].vld  = issue;
    vld_pipe_d[0].last = issue && pass_end;
    for (int i = 1; i < RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    if (flush) vld_pipe_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) assert (!(push && fifo_full && !pop));
  end

  stream_fifo #(
    .W     (DATA_W+1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i ({tag_out.last, mem_rdata}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign mem_en    = issue;
  assign mem_addr  = issue ? base_q + idx_q[ADDR_W-1:0] : '0;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign out_last  = !fifo_empty && fifo_head[DATA_W];
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_mem_stream_src.sv
// Drives two sources (read latency 1 and 3) with identical stimulus and checks
// each output stream against an expected word list built from the window rules.
module tb_mem_stream_src;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       loop_en = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b1;
  logic [6:0] base_addr = '0;
  logic [7:0] length = '0;

  logic       mem_en    [2];
  logic [6:0] mem_addr  [2];
  logic [7:0] mem_rdata [2];
  logic       out_valid [2];
  logic [7:0] out_data  [2];
  logic       out_last  [2];
  logic       busy      [2];
  logic       done      [2];

  logic [7:0] mem [128];
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 128; i++) mem[i] = 8'(i);

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] rpipe [L];
    always @(posedge clk) begin
      rpipe[0] <= mem_en[g] ? mem[mem_addr[g]] : 8'hFF;
      for (int k = 1; k < L; k++) rpipe[k] <= rpipe[k-1];
    end
    assign mem_rdata[g] = rpipe[L-1];

    mem_stream_src #(.ADDR_W(7), .DATA_W(8), .RD_LAT(L)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .loop_en   (loop_en),
      .abort     (abort),
      .mem_en    (mem_en[g]),
      .mem_addr  (mem_addr[g]),
      .mem_rdata (mem_rdata[g]),
      .out_valid (out_valid[g]),
      .out_data  (out_data[g]),
      .out_last  (out_last[g]),
      .out_ready (out_ready),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  int         checks = 0;
  int         failures = 0;
  int         t0 = 0;
  int         rd_idx[2], done_cnt[2], done_cyc[2], first_vld[2], last_hs[2];
  int         en_cnt[2], addr8[2], first_dat[2], last_dat[2];
  bit         busy1[2], stall_q[2];
  logic [8:0] hold_q[2];
  bit         chk_en = 1'b0;
  logic [8:0] exp_q[$];

  task automatic chk(input bit ok, input string nm, input int g, input int act, input int expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0d want=%0d", nm, g, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_stats();
    for (int g = 0; g < 2; g++) begin
      rd_idx[g] = 0;  done_cnt[g] = 0;  done_cyc[g] = -1; first_vld[g] = -1;
      last_hs[g] = -1; en_cnt[g] = 0;   addr8[g] = -1;    first_dat[g] = -1;
      last_dat[g] = -1; busy1[g] = 0;   stall_q[g] = 0;   hold_q[g] = '0;
    end
  endtask

  // Expected stream: word i of every pass is mem[(base+i) mod 128] = that address.
  task automatic build_exp(input int b, input int len, input int passes);
    exp_q.delete();
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < len; i++)
        exp_q.push_back({(i == len - 1), 8'((b + i) % 128)});
  endtask

  task automatic start_xfer(input int b, input int len, input int passes, input bit lp);
    build_exp(b, len, passes);
    clear_stats();
    start = 1'b1;
    base_addr = 7'(b);
    length = 8'(len);
    loop_en = lp;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int k;
    k = 0;
    while (!(done_cnt[0] >= 1 && done_cnt[1] >= 1) && k < maxc) begin
      tick();
      k++;
    end
    if (k >= maxc) chk(1'b0, "timeout_done", 0, k, maxc);
  endtask

  task automatic chk_reset_outs(input string nm);
    for (int g = 0; g < 2; g++)
      chk({mem_en[g], mem_addr[g], out_valid[g], out_data[g], out_last[g], busy[g], done[g]} == '0,
          nm, g, int'({mem_en[g], mem_addr[g], out_valid[g], out_data[g], out_last[g], busy[g], done[g]}), 0);
  endtask

  task automatic run_single();
    out_ready = 1'b1;
    start_xfer(0, 100, 1, 1'b0);
    wait_done(400);
    ticks(4);
    for (int g = 0; g < 2; g++) begin
      chk(first_vld[g] == ((g == 0) ? 3 : 5), "first_valid_cycle", g, first_vld[g], (g == 0) ? 3 : 5);
      chk(busy1[g], "busy_cycle1", g, int'(busy1[g]), 1);
      chk(rd_idx[g] == 100, "single_count", g, rd_idx[g], 100);
      chk(last_hs[g] - first_vld[g] == 99, "single_no_gaps", g, last_hs[g] - first_vld[g], 99);
      chk(last_dat[g] == 99, "single_last_word", g, last_dat[g], 99);
      chk(done_cyc[g] == last_hs[g] + 1, "single_done_cycle", g, done_cyc[g], last_hs[g] + 1);
      chk(done_cnt[g] == 1, "single_done_cnt", g, done_cnt[g], 1);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (chk_en && rst_n) begin
          for (int g = 0; g < 2; g++) begin
            int rel;
            logic [8:0] w;
            rel = cyc - t0;
            w = {out_last[g], out_data[g]};
            if (rel == 1) busy1[g] = busy[g];
            if (mem_en[g]) begin
              if (en_cnt[g] == 8) addr8[g] = int'(mem_addr[g]);
              en_cnt[g]++;
            end
            if (stall_q[g])
              chk(out_valid[g] && w == hold_q[g], "stall_hold", g, int'(w), int'(hold_q[g]));
            if (out_valid[g] && first_vld[g] < 0) first_vld[g] = rel;
            if (out_valid[g] && out_ready) begin
              if (rd_idx[g] < exp_q.size())
                chk(w == exp_q[rd_idx[g]], "word", g, int'(w), int'(exp_q[rd_idx[g]]));
              else
                chk(1'b0, "extra_word", g, int'(w), -1);
              if (rd_idx[g] == 0) first_dat[g] = int'(out_data[g]);
              last_dat[g] = int'(out_data[g]);
              last_hs[g] = rel;
              rd_idx[g]++;
            end
            if (done[g]) begin
              done_cnt[g]++;
              done_cyc[g] = rel;
              chk(rd_idx[g] == exp_q.size(), "done_all_words", g, rd_idx[g], exp_q.size());
              chk(!busy[g], "done_not_busy", g, int'(busy[g]), 0);
            end
            stall_q[g] = out_valid[g] && !out_ready;
            hold_q[g] = w;
          end
        end
      end
    join_none

    clear_stats();
    rst_n = 1'b0;
    ticks(2);
    chk_reset_outs("reset_outputs");
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    run_single();

    // zero length: no reads, done in cycle 1
    start_xfer(5, 0, 1, 1'b0);
    ticks(6);
    for (int g = 0; g < 2; g++) begin
      chk(done_cnt[g] == 1, "zero_done_cnt", g, done_cnt[g], 1);
      chk(done_cyc[g] == 1, "zero_done_cycle", g, done_cyc[g], 1);
      chk(en_cnt[g] == 0, "zero_no_reads", g, en_cnt[g], 0);
    end

    // address wrap: 120..127 then 0..7
    start_xfer(120, 16, 1, 1'b0);
    wait_done(200);
    ticks(4);
    for (int g = 0; g < 2; g++) begin
      chk(rd_idx[g] == 16, "wrap_count", g, rd_idx[g], 16);
      chk(addr8[g] == 0, "wrap_addr8", g, addr8[g], 0);
      chk(first_dat[g] == 120, "wrap_first", g, first_dat[g], 120);
      chk(last_dat[g] == 7, "wrap_last", g, last_dat[g], 7);
      chk(done_cnt[g] == 1, "wrap_done_cnt", g, done_cnt[g], 1);
    end

    // backpressure with random ready
    start_xfer(0, 40, 1, 1'b0);
    for (int k = 0; k < 2000 && !(done_cnt[0] >= 1 && done_cnt[1] >= 1); k++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    ticks(4);
    for (int g = 0; g < 2; g++) begin
      chk(rd_idx[g] == 40, "bp_count", g, rd_idx[g], 40);
      chk(done_cnt[g] == 1, "bp_done_cnt", g, done_cnt[g], 1);
    end

    // loop mode, loop_en dropped during the third pass
    start_xfer(10, 4, 3, 1'b1);
    for (int k = 0; k < 300 && !(done_cnt[0] >= 1 && done_cnt[1] >= 1); k++) begin
      if (en_cnt[0] >= 9) loop_en = 1'b0;
      tick();
    end
    loop_en = 1'b0;
    ticks(4);
    for (int g = 0; g < 2; g++) begin
      chk(rd_idx[g] == 12, "loop_count", g, rd_idx[g], 12);
      chk(en_cnt[g] == 12, "loop_reads", g, en_cnt[g], 12);
      chk(last_dat[g] == 13, "loop_last_word", g, last_dat[g], 13);
      chk(done_cnt[g] == 1, "loop_done_cnt", g, done_cnt[g], 1);
    end

    // abort in cycle 20, restart at base 50 in cycle 21
    start_xfer(0, 100, 1, 1'b0);
    for (int k = 0; k < 40 && (cyc - t0) < 20; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk(done_cnt[g] == 0, "abort_no_done", g, done_cnt[g], 0);
      chk(!out_valid[g], "abort_flushed", g, int'(out_valid[g]), 0);
      chk(!busy[g], "abort_idle", g, int'(busy[g]), 0);
    end
    start_xfer(50, 8, 1, 1'b0);
    wait_done(200);
    ticks(4);
    for (int g = 0; g < 2; g++) begin
      chk(first_dat[g] == 50, "abort_first_new", g, first_dat[g], 50);
      chk(rd_idx[g] == 8, "abort_new_count", g, rd_idx[g], 8);
      chk(done_cnt[g] == 1, "abort_new_done", g, done_cnt[g], 1);
    end

    // reset during DRAIN
    start_xfer(0, 10, 1, 1'b0);
    for (int k = 0; k < 50 && en_cnt[0] < 10; k++) tick();
    for (int g = 0; g < 2; g++) chk(busy[g] && !done[g], "drain_busy", g, int'(busy[g]), 1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    tick();
    chk_reset_outs("midreset_outputs");
    rst_n = 1'b1;
    clear_stats();
    chk_en = 1'b1;
    ticks(5);
    for (int g = 0; g < 2; g++) chk(done_cnt[g] == 0, "midreset_no_done", g, done_cnt[g], 0);

    run_single();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
